// File: rtl/washer_cycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : appliance_pkg
//  Description : Shared phase encodings and field widths for the washer
//                cycle sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package appliance_pkg;

    localparam int c_PHASE_W  = 3;
    localparam int c_REMAIN_W = 6;

    typedef enum logic [c_PHASE_W-1:0] {
        PH_IDLE  = 3'd0,
        PH_WASH  = 3'd1,
        PH_RINSE = 3'd2,
        PH_SPIN  = 3'd3,
        PH_DRAIN = 3'd4,
        PH_DONE  = 3'd5
    } phase_e;

    // Phases in which the drum motor runs and pause has an effect.
    function automatic logic is_run_phase(input phase_e p);
        return (p == PH_WASH) || (p == PH_RINSE) || (p == PH_SPIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/washer_cycle_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : washer_cycle_sequencer_if
//  Description : Config/control inputs and actuator/status outputs of the
//                washer cycle sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface washer_cycle_sequencer_if;
    import appliance_pkg::*;

    logic                  start;
    logic                  pause;
    logic                  abort;
    logic [4:0]            wash_t;
    logic [4:0]            rinse_t;
    logic [4:0]            spin_t;
    logic [4:0]            cloth;
    logic [c_PHASE_W-1:0]  phase;
    logic [c_REMAIN_W-1:0] remain;
    logic                  busy;
    logic                  valve_on;
    logic                  motor_on;
    logic                  drain_on;
    logic                  done;
    logic                  aborted;

    modport master (
        output start, pause, abort, wash_t, rinse_t, spin_t, cloth,
        input  phase, remain, busy, valve_on, motor_on, drain_on, done, aborted
    );

    modport slave (
        input  start, pause, abort, wash_t, rinse_t, spin_t, cloth,
        output phase, remain, busy, valve_on, motor_on, drain_on, done, aborted
    );

endinterface
`default_nettype wire

// File: rtl/washer_cycle_sequencer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : minute_prescaler
//  Description : Divides clk down to a one-cycle tick per timer minute.
//  Revision    : 1.0 - initial release
// ============================================================================
module minute_prescaler #(
    parameter int TICKS_PER_MIN = 600
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int                 c_CNT_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICKS_PER_MIN - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    assign tick = en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/washer_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : washer_cycle_sequencer
//  Description : Runs one wash/rinse/spin programme with abort-to-drain and
//                pause; drives valve, motor and drain enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module washer_cycle_sequencer
    import appliance_pkg::*;
#(
    parameter int TICKS_PER_MIN = 600,
    parameter int DRAIN_MIN     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    washer_cycle_sequencer_if.slave  bus
);

    localparam logic [c_REMAIN_W-1:0] c_DRAIN_REMAIN = c_REMAIN_W'(DRAIN_MIN);

    phase_e                r_phase;
    phase_e                w_phase_nxt;
    logic [c_REMAIN_W-1:0] r_remain;
    logic [c_REMAIN_W-1:0] w_remain_nxt;
    logic [4:0]            r_rinse;
    logic [4:0]            r_spin;
    logic                  r_pause_q;
    logic                  w_latch;
    logic                  w_load;
    logic                  w_tick;
    logic                  w_run;
    logic                  w_timed;
    logic                  w_frozen;

    assign w_run    = is_run_phase(r_phase);
    assign w_timed  = w_run || (r_phase == PH_DRAIN);
    assign w_frozen = w_run && bus.pause;

    minute_prescaler #(
        .TICKS_PER_MIN (TICKS_PER_MIN)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_load),
        .en   (w_timed && !w_frozen),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= PH_IDLE;
            r_remain  <= '0;
            r_rinse   <= '0;
            r_spin    <= '0;
            r_pause_q <= 1'b0;
        end else begin
            r_phase   <= w_phase_nxt;
            r_remain  <= w_remain_nxt;
            r_pause_q <= bus.pause;
            if (w_latch) begin
                r_rinse <= bus.rinse_t;
                r_spin  <= bus.spin_t;
            end
        end
    end

    // Abort outranks pause, which in turn holds both counting and the advance.
    always_comb begin
        w_phase_nxt  = r_phase;
        w_remain_nxt = r_remain;
        w_load       = 1'b0;
        w_latch      = 1'b0;
        case (r_phase)
            PH_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_phase_nxt  = PH_WASH;
                    w_remain_nxt = {1'b0, bus.wash_t} + {1'b0, bus.cloth};
                    w_load       = 1'b1;
                    w_latch      = 1'b1;
                end
            end
            PH_WASH, PH_RINSE, PH_SPIN: begin
                if (bus.abort) begin
                    w_phase_nxt  = PH_DRAIN;
                    w_remain_nxt = c_DRAIN_REMAIN;
                    w_load       = 1'b1;
                end else if (!bus.pause) begin
                    if (r_remain == '0) begin
                        w_load = 1'b1;
                        case (r_phase)
                            PH_WASH: begin
                                w_phase_nxt  = PH_RINSE;
                                w_remain_nxt = {1'b0, r_rinse};
                            end
                            PH_RINSE: begin
                                w_phase_nxt  = PH_SPIN;
                                w_remain_nxt = {1'b0, r_spin};
                            end
                            default: begin
                                w_phase_nxt  = PH_DONE;
                                w_remain_nxt = '0;
                            end
                        endcase
                    end else if (w_tick) begin
                        w_remain_nxt = r_remain - c_REMAIN_W'(1);
                    end
                end
            end
            PH_DRAIN: begin
                if (r_remain == '0) begin
                    w_phase_nxt = PH_IDLE;
                end else if (w_tick) begin
                    w_remain_nxt = r_remain - c_REMAIN_W'(1);
                end
            end
            PH_DONE: begin
                w_phase_nxt = PH_IDLE;
            end
            default: begin
                w_phase_nxt  = PH_IDLE;
                w_remain_nxt = '0;
            end
        endcase
    end

    // Motor uses the registered pause so no input reaches an output combinationally.
    assign bus.phase    = r_phase;
    assign bus.remain   = r_remain;
    assign bus.busy     = (r_phase != PH_IDLE) && (r_phase != PH_DONE);
    assign bus.valve_on = (r_phase == PH_WASH) || (r_phase == PH_RINSE);
    assign bus.motor_on = w_run && !r_pause_q;
    assign bus.drain_on = (r_phase == PH_SPIN) || (r_phase == PH_DRAIN);
    assign bus.done     = (r_phase == PH_DONE);
    assign bus.aborted  = (r_phase == PH_DRAIN) && (r_remain == '0);

endmodule
`default_nettype wire
